// File: rtl/proc_pkg.sv
// Shared constants and fetch FSM encoding for the instruction fetch unit.
package proc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular buffer with read/write pointers and an occupancy
// count. Besides the current count it exposes the post-update count and the
// post-update head entry so the owner can register its output stage from
// the head without an extra cycle of latency.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             head_next_valid,
  output logic [WIDTH-1:0] head_next_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count update and look-ahead of the head entry after this cycle.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    head_next_valid = 1'b0;
    head_next_data  = mem[rd_ptr_q];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
      head_next_valid = (count_d != '0);
      // When the buffer drains to empty this cycle, the pushed word becomes
      // the head; it is not yet visible in mem.
      if (push && (count_q == CNT_W'(pop))) begin
        head_next_data = push_data;
      end else begin
        head_next_data = mem[rd_ptr_d];
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a synchronous ROM, tags each
// read with an epoch so redirects can kill stale responses, and presents
// buffered {pc, instr} words to decode through a registered output stage.
module instr_fetch_unit #(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int INSTR_W = proc_pkg::INSTR_W,
  parameter int DEPTH = proc_pkg::DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  import proc_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               epoch_q, epoch_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  tag_pc_q, tag_pc_d;
  logic               tag_epoch_q, tag_epoch_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   occ_next;
  logic               head_next_valid;
  logic [ENTRY_W-1:0] head_next_data;
  logic [ENTRY_W-1:0] push_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .flush           (redirect),
    .push            (push),
    .push_data       (push_data),
    .pop             (pop),
    .count           (count),
    .count_next      (count_next),
    .head_next_valid (head_next_valid),
    .head_next_data  (head_next_data)
  );

  // Issue, response acceptance, pop, PC/epoch and in-flight tag updates.
  // Occupancy includes the outstanding read so a response always has a slot.
  always_comb begin
    occ         = OCC_W'(count) + OCC_W'(inflight_q);
    issue       = (state_q == FETCH) && enable && !redirect && (occ < DEPTH_OCC);
    // A response landing in the redirect cycle belongs to the old stream.
    push        = inflight_q && (tag_epoch_q == epoch_q) && !redirect;
    pop         = out_valid_q && out_ready && !redirect;
    push_data   = {tag_pc_q, rom_data};
    occ_next    = OCC_W'(count_next) + OCC_W'(issue);

    fetch_pc_d  = fetch_pc_q;
    epoch_d     = epoch_q;
    inflight_d  = issue;
    tag_pc_d    = tag_pc_q;
    tag_epoch_d = tag_epoch_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    if (issue) begin
      tag_pc_d    = fetch_pc_q;
      tag_epoch_d = epoch_q;
    end
  end

  // Fetch FSM next state: enable gates everything, FULL tracks reservation.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (occ_next == DEPTH_OCC) state_d = FULL;
        FULL:    if (occ_next < DEPTH_OCC) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage follows the buffer head; holds its last word when empty.
  always_comb begin
    out_valid_d = head_next_valid;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (head_next_valid) begin
      out_pc_d    = head_next_data[ENTRY_W-1:INSTR_W];
      out_instr_d = head_next_data[INSTR_W-1:0];
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      epoch_q     <= 1'b0;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      tag_epoch_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      epoch_q     <= epoch_d;
      inflight_q  <= inflight_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign rom_req   = issue;
  assign rom_addr  = fetch_pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule
